// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and frame shape.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-bit 2-flop synchroniser for asynchronous inputs; every stage resets to 1.
module uart_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= d[gi];
          sync_reg <= meta_reg;
        end
      end

      assign q[gi] = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/uart_rx_v.sv
// 8N1 UART receiver: oversamples the synchronised line and samples each bit at its centre.
module uart_rx_v
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 300000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_rx_dv,
  output logic       o_frame_err,
  output logic       o_active
);

  localparam int C  = CLK_FREQ / BAUD_RATE;
  localparam int H  = C / 2;
  localparam int CW = $clog2(C);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_LAST   = CW'(C - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] BIT_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  logic rx_s;

  uart_sync #(.WIDTH(1)) u_sync (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .d    (i_rx),
    .q    (rx_s)
  );

  uart_state_t          state_reg, state_next;
  logic [CW-1:0]        clk_cnt_reg, clk_cnt_next;
  logic [IW-1:0]        bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shreg_reg, shreg_next;
  logic [7:0]           data_reg, data_next;
  logic                 rx_dv_reg, rx_dv_next;
  logic                 frame_err_reg, frame_err_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      clk_cnt_reg   <= '0;
      bit_idx_reg   <= '0;
      shreg_reg     <= '0;
      data_reg      <= 8'h00;
      rx_dv_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      clk_cnt_reg   <= clk_cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shreg_reg     <= shreg_next;
      data_reg      <= data_next;
      rx_dv_reg     <= rx_dv_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clk_cnt_next   = clk_cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shreg_next     = shreg_reg;
    data_next      = data_reg;
    rx_dv_next     = 1'b0;
    frame_err_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        clk_cnt_next = '0;
        bit_idx_next = '0;
        if (!rx_s) state_next = START;
      end
      // Half a bit in: confirm the start bit so short glitches fall back to IDLE.
      START: begin
        if (clk_cnt_reg == H_LAST) begin
          clk_cnt_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_ONE;
        end
      end
      DATA: begin
        if (clk_cnt_reg == C_LAST) begin
          clk_cnt_next             = '0;
          shreg_next[bit_idx_reg]  = rx_s;
          if (bit_idx_reg == BIT_LAST) state_next = STOP;
          else bit_idx_next = bit_idx_reg + IDX_ONE;
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_ONE;
        end
      end
      // Leave at the stop-bit centre so a zero-gap next start bit is still caught.
      STOP: begin
        if (clk_cnt_reg == C_LAST) begin
          clk_cnt_next = '0;
          if (rx_s) begin
            data_next  = shreg_reg;
            rx_dv_next = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_ONE;
        end
      end
      WAIT_IDLE: begin
        clk_cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_data      = data_reg;
  assign o_rx_dv     = rx_dv_reg;
  assign o_frame_err = frame_err_reg;
  assign o_active    = (state_reg == START) || (state_reg == DATA) || (state_reg == STOP);

endmodule

// File: tb/tb_uart_rx_v.sv
// Randomised scoreboard bench for uart_rx_v using a reduced clock/baud ratio (C=64).
module tb_uart_rx_v;

  localparam int CLK_FREQ  = 6_400_000;
  localparam int BAUD_RATE = 100_000;
  localparam int C   = CLK_FREQ / BAUD_RATE;
  localparam int H   = C / 2;
  localparam int LAT = 3 + H + 9 * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       dv;
  logic       ferr;
  logic       active;

  always #5 clk = ~clk;

  uart_rx_v #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx       (rx),
    .o_data     (data),
    .o_rx_dv    (dv),
    .o_frame_err(ferr),
    .o_active   (active)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
    bit         chk_time;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: a frame is start(0), 8 data bits LSB first, stop bit; result lands LAT edges after the fall.
  task automatic send_frame(input logic [7:0] b, input int bit_cyc, input bit stop_val,
                            input bit chk_time, input int gap);
    exp_t       e;
    logic [9:0] bits;
    @(negedge clk);
    e.cyc      = cyc + LAT;
    e.chk_time = chk_time;
    e.is_err   = !stop_val;
    if (stop_val) begin
      e.data    = b;
      last_good = b;
    end else begin
      e.data = last_good;
    end
    sb.push_back(e);
    bits = {stop_val, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (bit_cyc) @(negedge clk);
    end
    if (stop_val) begin
      rx = 1'b1;
      repeat (gap) @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (dv || ferr)) begin
      check("dv_ferr_exclusive", 32'(dv && ferr), 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: dv=%0b ferr=%0b data=0x%h, required no strobe (cycle %0d)",
                 dv, ferr, data, cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_kind_ferr", 32'(ferr), 32'(e.is_err));
        check("o_data", 32'(data), 32'(e.data));
        if (e.chk_time)
          check("strobe_cycle_offset",
                ((cyc - e.cyc) >= -1 && (cyc - e.cyc) <= 1) ? 32'd0 : 32'(cyc - e.cyc), 32'd0);
        $display("rx %s data=0x%h cycle=%0d expected_cycle=%0d",
                 ferr ? "frame_err" : "byte", data, cyc, e.cyc);
      end
    end
  end

  initial begin
    int         act_cnt;
    logic [7:0] b;
    logic [7:0] partial;

    repeat (3) @(negedge clk);
    check("reset_o_data", 32'(data), 32'd0);
    check("reset_o_rx_dv", 32'(dv), 32'd0);
    check("reset_o_frame_err", 32'(ferr), 32'd0);
    check("reset_o_active", 32'(active), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'hA5, C, 1'b1, 1'b1, C);

    send_frame(8'h00, C, 1'b1, 1'b1, 0);
    send_frame(8'hFF, C, 1'b1, 1'b1, C);

    // Short low glitch: START for H cycles, then back to IDLE without a strobe.
    act_cnt = 0;
    @(negedge clk);
    rx = 1'b0;
    for (int i = 0; i < 2 * C; i++) begin
      @(negedge clk);
      if (i == 4) rx = 1'b1;
      if (active) act_cnt++;
    end
    check("glitch_active_cycles", 32'(act_cnt), 32'(H));
    $display("glitch: o_active high for %0d cycles", act_cnt);

    // Bad stop bit followed by a held break, then a clean frame.
    send_frame(8'h3C, C, 1'b0, 1'b1, 0);
    repeat (3 * C) @(negedge clk);
    check("break_o_active", 32'(active), 32'd0);
    rx = 1'b1;
    repeat (C) @(negedge clk);
    send_frame(8'h81, C, 1'b1, 1'b1, C);

    // Reset asserted halfway through data bit 4.
    partial = 8'h33;
    @(negedge clk);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      repeat (C) @(negedge clk);
    end
    rx = partial[4];
    repeat (H) @(negedge clk);
    check("midframe_o_active_before_reset", 32'(active), 32'd1);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    check("midreset_o_data", 32'(data), 32'd0);
    check("midreset_o_rx_dv", 32'(dv), 32'd0);
    check("midreset_o_frame_err", 32'(ferr), 32'd0);
    check("midreset_o_active", 32'(active), 32'd0);
    $display("reset asserted during data bit 4");
    last_good = 8'h00;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (C) @(negedge clk);
    send_frame(8'h5A, C, 1'b1, 1'b1, C);

    // +3% and -3% baud.
    send_frame(8'hC3, (C * 100) / 103, 1'b1, 1'b0, C);
    send_frame(8'hC3, (C * 103) / 100, 1'b1, 1'b0, C);

    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, C, 1'b1, 1'b1, int'($urandom_range(0, C)));
    end

    for (int i = 0; i < 20 * C && sb.size() != 0; i++) @(negedge clk);
    repeat (2 * C) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
